// File: rtl/axi_hp_pkg.sv
// Shared AXI3 HP-port constants and the write-arbiter state encoding.
package axi_hp_pkg;

  localparam logic [4:0] AXI_BURST_LEN  = 5'd16;
  localparam logic [3:0] AXI_LAST_BEAT  = 4'd15;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [5:0] IDBASE_DEFAULT = 6'b111100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Requester-side and HP-port-side signals of the shared AXI3 write arbiter.
interface axi_wr_arbiter_if #(parameter int NREQ = 2);

  logic [NREQ*32-1:0] req_awaddr;
  logic [NREQ-1:0]    req_awvalid;
  logic [NREQ-1:0]    req_awready;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_wvalid;
  logic [NREQ-1:0]    req_wlast;
  logic [NREQ-1:0]    req_wready;
  logic [NREQ-1:0]    req_bdone;

  logic [31:0] AXI_awaddr;
  logic        AXI_awvalid;
  logic        AXI_awready;
  logic [5:0]  AXI_awid;
  logic [3:0]  AXI_awlen;
  logic [2:0]  AXI_awsize;
  logic [1:0]  AXI_awburst;
  logic [31:0] AXI_wdata;
  logic        AXI_wvalid;
  logic        AXI_wready;
  logic        AXI_wlast;
  logic [5:0]  AXI_wid;
  logic        AXI_bvalid;
  logic [5:0]  AXI_bid;
  logic [1:0]  AXI_bresp;
  logic        AXI_bready;
  logic        proto_err;

  // Arbiter view: drives the HP port and the per-requester handshakes.
  modport master (
    input  req_awaddr, req_awvalid, req_wdata, req_wvalid, req_wlast,
    input  AXI_awready, AXI_wready, AXI_bvalid, AXI_bid, AXI_bresp,
    output req_awready, req_wready, req_bdone,
    output AXI_awaddr, AXI_awvalid, AXI_awid, AXI_awlen, AXI_awsize, AXI_awburst,
    output AXI_wdata, AXI_wvalid, AXI_wlast, AXI_wid, AXI_bready, proto_err
  );

  modport slave (
    output req_awaddr, req_awvalid, req_wdata, req_wvalid, req_wlast,
    output AXI_awready, AXI_wready, AXI_bvalid, AXI_bid, AXI_bresp,
    input  req_awready, req_wready, req_bdone,
    input  AXI_awaddr, AXI_awvalid, AXI_awid, AXI_awlen, AXI_awsize, AXI_awburst,
    input  AXI_wdata, AXI_wvalid, AXI_wlast, AXI_wid, AXI_bready, proto_err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester set searching upward from last+1, wrapping.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      idx,
  output logic            any
);

  logic [3:0] req_pad_s;
  logic [1:0] cand_s;

  assign req_pad_s = 4'(req);
  assign any       = |req;

  // Walk candidates from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx    = 2'd0;
    cand_s = 2'd0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = 2'((int'(last) + k) % NREQ);
      idx    = req_pad_s[cand_s] ? cand_s : idx;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin sharing of one AXI3 HP write port among NREQ 16-beat burst requesters.
module axi_wr_arbiter
  import axi_hp_pkg::*;
#(
  parameter int          NREQ   = 2,
  parameter logic [5:0]  IDBASE = IDBASE_DEFAULT
) (
  input  logic             AXI_clk,
  input  logic             rst,
  axi_wr_arbiter_if.master bus
);

  arb_state_e   state_r, state_s;
  logic [1:0]   grant_r, grant_s;
  logic [1:0]   last_r, last_s;
  logic [3:0]   beat_r, beat_s;
  logic [NREQ-1:0] bdone_r;
  logic         proto_err_r;

  logic         pick_any_s;
  logic [1:0]   pick_idx_s;
  logic [3:0]   awvalid_pad_s, wvalid_pad_s, wlast_pad_s;
  logic [127:0] awaddr_pad_s, wdata_pad_s;
  logic [5:0]   id_s;
  logic         aw_hs_s, w_hs_s, last_beat_s;
  logic         wlast_bad_s, b_match_s, b_err_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (bus.req_awvalid),
    .last (last_r),
    .idx  (pick_idx_s),
    .any  (pick_any_s)
  );

  // Zero-padded views so a 2-bit grant can index any NREQ safely.
  assign awvalid_pad_s = 4'(bus.req_awvalid);
  assign wvalid_pad_s  = 4'(bus.req_wvalid);
  assign wlast_pad_s   = 4'(bus.req_wlast);
  assign awaddr_pad_s  = 128'(bus.req_awaddr);
  assign wdata_pad_s   = 128'(bus.req_wdata);

  assign id_s        = IDBASE | {4'b0000, grant_r};
  assign last_beat_s = (beat_r == AXI_LAST_BEAT);
  assign aw_hs_s     = (state_r == ST_ADDR) && awvalid_pad_s[grant_r] && bus.AXI_awready;
  assign w_hs_s      = (state_r == ST_DATA) && wvalid_pad_s[grant_r] && bus.AXI_wready;
  assign wlast_bad_s = w_hs_s && (wlast_pad_s[grant_r] != last_beat_s);
  assign b_match_s   = bus.AXI_bvalid && (bus.AXI_bid[5:2] == IDBASE[5:2]) &&
                       ({1'b0, bus.AXI_bid[1:0]} < 3'(NREQ));
  assign b_err_s     = bus.AXI_bvalid && (bus.AXI_bresp != AXI_RESP_OKAY);

  assign bus.AXI_awid    = id_s;
  assign bus.AXI_wid     = id_s;
  assign bus.AXI_awlen   = 4'(AXI_BURST_LEN - 5'd1);
  assign bus.AXI_awsize  = AXI_SIZE_4B;
  assign bus.AXI_awburst = AXI_BURST_INCR;
  assign bus.AXI_bready  = 1'b1;
  assign bus.req_bdone   = bdone_r;
  assign bus.proto_err   = proto_err_r;

  // State, grant, round-robin pointer and beat counter registers.
  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      grant_r <= 2'd0;
      last_r  <= 2'(NREQ - 1);
      beat_r  <= 4'd0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      beat_r  <= beat_s;
    end
  end

  // Next-state: arbitrate only in IDLE, hold a burst until its 16th beat.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    beat_s  = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_s = ST_ADDR;
          grant_s = pick_idx_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (aw_hs_s) begin
          state_s = ST_DATA;
          beat_s  = 4'd0;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (w_hs_s && last_beat_s) begin
          state_s = ST_IDLE;
          last_s  = grant_r;
        end else if (w_hs_s) begin
          beat_s = beat_r + 4'd1;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Steer the granted requester onto AW in ADDR and onto W in DATA.
  always_comb begin
    bus.AXI_awvalid = 1'b0;
    bus.AXI_awaddr  = 32'h0000_0000;
    bus.AXI_wvalid  = 1'b0;
    bus.AXI_wdata   = 32'h0000_0000;
    bus.AXI_wlast   = 1'b0;
    bus.req_awready = '0;
    bus.req_wready  = '0;
    case (state_r)
      ST_ADDR: begin
        bus.AXI_awvalid = awvalid_pad_s[grant_r];
        bus.AXI_awaddr  = awaddr_pad_s[{grant_r, 5'b00000} +: 32];
        bus.req_awready = bus.AXI_awready ? (NREQ'(1'b1) << grant_r) : '0;
      end
      ST_DATA: begin
        bus.AXI_wvalid = wvalid_pad_s[grant_r];
        bus.AXI_wdata  = wdata_pad_s[{grant_r, 5'b00000} +: 32];
        bus.AXI_wlast  = last_beat_s;
        bus.req_wready = bus.AXI_wready ? (NREQ'(1'b1) << grant_r) : '0;
      end
      default: begin
        bus.AXI_awvalid = 1'b0;
      end
    endcase
  end

  // B routing to per-requester pulses and the sticky protocol error flag.
  always_ff @(posedge AXI_clk or negedge rst) begin
    if (!rst) begin
      bdone_r     <= '0;
      proto_err_r <= 1'b0;
    end else begin
      bdone_r     <= b_match_s ? (NREQ'(1'b1) << bus.AXI_bid[1:0]) : '0;
      proto_err_r <= proto_err_r | wlast_bad_s | b_err_s;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: directed bursts, monitor pops expected AW/W/B.
module tb_axi_wr_arbiter;

  localparam int NREQ = 2;

  logic AXI_clk  = 1'b0;
  logic rst      = 1'b0;
  logic wready_r = 1'b1;
  logic bp_en    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  logic [37:0]     exp_aw[$];
  logic [38:0]     exp_w[$];
  logic [NREQ-1:0] exp_b[$];

  axi_wr_arbiter_if #(.NREQ(NREQ)) bus ();

  axi_wr_arbiter #(.NREQ(NREQ), .IDBASE(6'b111100)) dut (
    .AXI_clk (AXI_clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  always #5 AXI_clk = ~AXI_clk;

  assign bus.AXI_wready = wready_r;
  always @(posedge AXI_clk) wready_r <= bp_en ? ~wready_r : 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Monitor: every AW/W handshake and every bdone pulse consumes one expectation.
  always @(negedge AXI_clk) begin
    if (rst) begin
      if (bus.AXI_awvalid && bus.AXI_awready) begin
        if (exp_aw.size() == 0) fail("aw_unexpected", 64'({bus.AXI_awid, bus.AXI_awaddr}));
        else chk("aw", 64'({bus.AXI_awid, bus.AXI_awaddr}), 64'(exp_aw.pop_front()));
      end
      if (bus.AXI_wvalid && bus.AXI_wready) begin
        if (exp_w.size() == 0) fail("w_unexpected", 64'({bus.AXI_wid, bus.AXI_wlast, bus.AXI_wdata}));
        else chk("w", 64'({bus.AXI_wid, bus.AXI_wlast, bus.AXI_wdata}), 64'(exp_w.pop_front()));
      end
      if (bus.req_bdone != '0) begin
        if (exp_b.size() == 0) fail("bdone_unexpected", 64'(bus.req_bdone));
        else chk("bdone", 64'(bus.req_bdone), 64'(exp_b.pop_front()));
      end
    end
  end

  task automatic push_burst(input int i, input logic [31:0] addr, input int nbeats);
    exp_aw.push_back({6'h3C | 6'(i), addr});
    for (int b = 0; b < nbeats; b++) begin
      exp_w.push_back({6'h3C | 6'(i), (b == 15), addr + 32'(b)});
    end
  endtask

  task automatic run_req(input int i, input logic [31:0] addr, input int bad,
                         input int nbeats, output int lat);
    int n;
    bus.req_awaddr[i*32 +: 32] = addr;
    bus.req_awvalid[i] = 1'b1;
    n = 0;
    do begin @(negedge AXI_clk); n++; end while (bus.req_awready[i] !== 1'b1 && n < 300);
    lat = n;
    if (bus.req_awready[i] !== 1'b1) fail("aw_timeout", 64'(i));
    @(posedge AXI_clk); #1;
    bus.req_awvalid[i] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      bus.req_wdata[i*32 +: 32] = addr + 32'(b);
      bus.req_wlast[i]  = (b == 15) || (b == bad);
      bus.req_wvalid[i] = 1'b1;
      n = 0;
      do begin @(negedge AXI_clk); n++; end while (bus.req_wready[i] !== 1'b1 && n < 300);
      if (bus.req_wready[i] !== 1'b1) fail("w_timeout", 64'(b));
      @(posedge AXI_clk); #1;
    end
    if (nbeats == 16) begin
      @(negedge AXI_clk);
      chk("idle_after_last_beat", 64'({bus.AXI_wvalid, bus.req_wready[i]}), 64'd0);
      bus.req_wvalid[i] = 1'b0;
      bus.req_wlast[i]  = 1'b0;
    end
  endtask

  task automatic send_b(input logic [5:0] bid, input logic [1:0] resp);
    @(posedge AXI_clk); #1;
    bus.AXI_bvalid = 1'b1;
    bus.AXI_bid    = bid;
    bus.AXI_bresp  = resp;
    @(negedge AXI_clk);
    chk("bdone_not_early", 64'(bus.req_bdone), 64'd0);
    @(posedge AXI_clk); #1;
    bus.AXI_bvalid = 1'b0;
    @(negedge AXI_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valids"}, 64'({bus.AXI_awvalid, bus.AXI_wvalid, bus.AXI_wlast}), 64'd0);
    chk({tag, "_readys"}, 64'({bus.req_awready, bus.req_wready}), 64'd0);
    chk({tag, "_bdone_err"}, 64'({bus.req_bdone, bus.proto_err}), 64'd0);
    chk({tag, "_bready"}, 64'(bus.AXI_bready), 64'd1);
  endtask

  initial begin
    int lat;
    bus.req_awaddr  = '0;
    bus.req_awvalid = '0;
    bus.req_wdata   = '0;
    bus.req_wvalid  = '0;
    bus.req_wlast   = '0;
    bus.AXI_awready = 1'b1;
    bus.AXI_bvalid  = 1'b0;
    bus.AXI_bid     = 6'h00;
    bus.AXI_bresp   = 2'b00;

    repeat (2) @(negedge AXI_clk);
    check_reset_outputs("reset");
    @(posedge AXI_clk); #1;
    rst = 1'b1;

    // Single burst from requester 0, then its B response.
    push_burst(0, 32'h1000_0000, 16);
    run_req(0, 32'h1000_0000, -1, 16, lat);
    chk("aw_latency", 64'(lat), 64'd2);
    exp_b.push_back(2'b01);
    send_b(6'h3C, 2'b00);

    // Backpressure: wready toggles every cycle.
    bp_en = 1'b1;
    push_burst(1, 32'h2000_0000, 16);
    run_req(1, 32'h2000_0000, -1, 16, lat);
    bp_en = 1'b0;

    // Contention: last grant was 1, so order is 0,1,0,1.
    push_burst(0, 32'h3000_0000, 16);
    push_burst(1, 32'h3100_0000, 16);
    push_burst(0, 32'h3200_0000, 16);
    push_burst(1, 32'h3300_0000, 16);
    fork
      begin
        int l0;
        run_req(0, 32'h3000_0000, -1, 16, l0);
        run_req(0, 32'h3200_0000, -1, 16, l0);
      end
      begin
        int l1;
        run_req(1, 32'h3100_0000, -1, 16, l1);
        run_req(1, 32'h3300_0000, -1, 16, l1);
      end
    join

    // Requester 0 burst leaves last=0; foreign and out-of-range BIDs are ignored.
    push_burst(0, 32'h4000_0000, 16);
    run_req(0, 32'h4000_0000, -1, 16, lat);
    send_b(6'h05, 2'b00);
    chk("foreign_bid", 64'(bus.req_bdone), 64'd0);
    send_b(6'h3E, 2'b00);
    chk("bid_out_of_range", 64'(bus.req_bdone), 64'd0);
    chk("err_clear_before_reset", 64'(bus.proto_err), 64'd0);

    // Reset at beat 9 of a requester 1 burst.
    push_burst(1, 32'h5000_0000, 9);
    run_req(1, 32'h5000_0000, -1, 9, lat);
    rst = 1'b0;
    @(negedge AXI_clk);
    check_reset_outputs("mid_reset");
    bus.req_wvalid[1] = 1'b0;
    bus.req_wlast[1]  = 1'b0;
    @(posedge AXI_clk); #1;
    rst = 1'b1;
    push_burst(0, 32'h6000_0000, 16);
    push_burst(1, 32'h6100_0000, 16);
    fork
      begin
        int l0;
        run_req(0, 32'h6000_0000, -1, 16, l0);
      end
      begin
        int l1;
        run_req(1, 32'h6100_0000, -1, 16, l1);
      end
    join

    // Early wlast on beat 7 from requester 1.
    chk("err_before_bad_wlast", 64'(bus.proto_err), 64'd0);
    push_burst(1, 32'h7000_0000, 16);
    run_req(1, 32'h7000_0000, 7, 16, lat);
    chk("err_after_bad_wlast", 64'(bus.proto_err), 64'd1);
    repeat (3) @(negedge AXI_clk);
    chk("err_sticky", 64'(bus.proto_err), 64'd1);

    // SLVERR on a matching BID: bdone still pulses, error flag sets.
    @(posedge AXI_clk); #1;
    rst = 1'b0;
    @(posedge AXI_clk); #1;
    rst = 1'b1;
    @(negedge AXI_clk);
    chk("err_cleared_by_reset", 64'(bus.proto_err), 64'd0);
    exp_b.push_back(2'b10);
    send_b(6'h3D, 2'b10);
    chk("err_after_slverr", 64'(bus.proto_err), 64'd1);

    repeat (3) @(negedge AXI_clk);
    chk("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_drained", 64'(exp_w.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Shares one AXI3 HP write port (AW/W/B channels) between `NREQ` stream-to-AXI write requesters. Each requester issues fixed 16-beat INCR bursts of 32-bit words. The block grants the port round-robin, one whole burst at a time, and tags each burst with a per-requester AWID. It routes B responses back as per-requester completion pulses and enforces the 16-beat burst length on the W channel. It sits between the stream-to-AXI controllers and the PS HP port, all in the `AXI_clk` domain.

## Interface
Parameters:
- `NREQ`, 2 — number of requesters, 2..4
- `IDBASE`, 6'b111100 — AWID is `IDBASE | grant index`; the low 2 bits of `IDBASE` must be 0

Ports:
- `AXI_clk` in 1 — the single clock
- `rst` in 1 — asynchronous, active-low reset
- `req_awaddr` in NREQ*32 — burst start address per requester; requester i occupies bits [32i+31:32i]
- `req_awvalid` in NREQ — burst request, held until `req_awready`
- `req_awready` out NREQ — address accepted
- `req_wdata` in NREQ*32 — write beat data
- `req_wvalid` in NREQ — beat valid
- `req_wlast` in NREQ — requester's own last-beat marker, checked only
- `req_wready` out NREQ — beat accepted
- `req_bdone` out NREQ — one-cycle pulse when the requester's burst response arrives
- `AXI_awaddr` out 32, `AXI_awvalid` out 1, `AXI_awready` in 1, `AXI_awid` out 6
- `AXI_wdata` out 32, `AXI_wvalid` out 1, `AXI_wready` in 1, `AXI_wlast` out 1, `AXI_wid` out 6
- `AXI_bvalid` in 1, `AXI_bid` in 6, `AXI_bresp` in 2, `AXI_bready` out 1
- `proto_err` out 1 — sticky; set on a `wlast` mismatch or a SLVERR/DECERR response; cleared only by reset

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any `req_awvalid` is set, select the first set bit searching from `last+1` upward, wrapping modulo NREQ.
  - Register the winner in `grant` and go to ADDR.
  - With no requests, stay in IDLE.
- ADDR:
  - `AXI_awvalid = req_awvalid[grant]`, `AXI_awaddr = req_awaddr[grant]`, `AXI_awid = IDBASE | grant`.
  - `req_awready[grant] = AXI_awready`; the other ready bits are 0.
  - On the AW handshake: go to DATA and set `beat <= 0`.
- DATA:
  - `AXI_wvalid = req_wvalid[grant]`, `AXI_wdata = req_wdata[grant]`, `AXI_wid = AXI_awid`, `AXI_wlast = (beat == 15)`.
  - `req_wready[grant] = AXI_wready`; the other ready bits are 0.
  - On each W handshake, `beat` increments. `beat` is 4 bits and never wraps within DATA.
  - On the handshake at `beat == 15`: set `last <= grant` and go to IDLE.
- `wlast` check: if `req_wlast[grant] != (beat == 15)` on any W handshake, set `proto_err`. The burst still completes at exactly 16 beats.
- B channel:
  - `AXI_bready` is tied to 1.
  - When `AXI_bvalid` is set and `AXI_bid[5:2] == IDBASE[5:2]`, pulse `req_bdone[AXI_bid[1:0]]` for 1 cycle.
  - Any other BID, or an index ≥ NREQ, is ignored.
  - `AXI_bresp != 0` sets `proto_err`.
- Only one burst is in flight on AW/W at a time. B responses may arrive during any state, including the DATA phase of a later burst.

## Timing
- Reset values:
  - FSM is IDLE, `grant = 0`, `last = NREQ-1` (requester 0 wins first), `beat = 0`.
  - All `*valid`, `*ready`, `req_bdone` and `proto_err` are 0.
  - `AXI_bready` is 1.
- Latency:
  - `req_awvalid` to `AXI_awvalid`: 1 cycle (the IDLE→ADDR registration).
  - W channel: combinational pass-through, 0 cycles.
  - `AXI_bvalid` to `req_bdone`: registered, 1 cycle.
- Arbitration is decided only in IDLE. A request arriving during ADDR or DATA waits; a burst is never preempted.
- Minimum per-burst occupancy is 1 (IDLE) + 1 (ADDR) + 16 (DATA) = 18 cycles.
- Dropping `req_awvalid` while in ADDR is a requester violation. The arbiter simply holds ADDR until `AXI_awvalid` and `AXI_awready` handshake.
- Reset asserted mid-burst returns all state to reset values on the next edge. The partial burst is abandoned and no `req_bdone` is generated for it.
- A W handshake at `beat == 15` and a B arrival in the same cycle are independent and both are honoured.

## Structure
- Shared package `axi_hp_pkg` holds:
  - AXI3 constants: burst length 16, size 3'b010, INCR burst 2'b01, OKAY response 2'b00.
  - The FSM state enum.
  - `IDBASE` default.
- The round-robin picker is a natural combinational sub-module, `rr_pick`: inputs `req`[NREQ] and `last`; outputs `idx` and `any`.
- The FSM, beat counter and B router live in `axi_wr_arbiter`.

## Test plan
- Single request: requester 0 asks for address 0x1000_0000. Expect `AXI_awvalid` 1 cycle later with `AXI_awid = 0x3C`. Expect 16 beats, `AXI_wlast` only on beat 15. Return B with `bid = 0x3C` and expect a `req_bdone[0]` pulse 1 cycle after.
- Contention: requesters 0 and 1 request continuously. Grants must alternate 0,1,0,1 and AWIDs must alternate 0x3C,0x3D.
- Backpressure: `AXI_wready` toggles every other cycle. All 16 beats pass in order, `beat` holds while ready is low, and the FSM reaches IDLE exactly after the 16th handshake.
- Bad `wlast`: requester 1 asserts `req_wlast` on beat 7. `proto_err` goes to 1 and stays; `AXI_wlast` still asserts only on beat 15.
- Foreign and error responses: BID 0x05 produces no `req_bdone`. BID 0x3D with `bresp = 2'b10` pulses `req_bdone[1]` and sets `proto_err`.
- Reset mid-DATA: drop `rst` at beat 9. All outputs return to reset values; after release, requester 0 wins the next arbitration and its burst is 16 beats.
